jk_ff_checker: RTL and testbench

- Synthesizable response checker for a JK flip-flop DUT. It is the receiving end of the flip-flop stimulus path: a bench or BIST driver supplies j/k and the DUT's own reset, and this block observes the same j/k/reset plus DUT q.
- It runs a cycle-accurate JK reference model, compares it against dut_q, and reports mismatches with saturating counters.
- It sits beside the DUT under a self-check wrapper in practice/flip_flop.

---
 rtl/jk_ff_checker.sv | 176 +++++++++++++++++
 tb/tb_jk_ff_checker.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_ff_checker.sv
// Response checker for a JK flip-flop DUT: runs a cycle-accurate JK reference model,
// aligns it to the DUT latency and counts compares and mismatches with saturating counters.
module jk_ff_checker #(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned LAT          = 1,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             clr,
    input  logic             j,
    input  logic             k,
    input  logic             dut_rstn,
    input  logic             dut_q,
    output logic             exp_q,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [1:0]       state
);

    localparam int unsigned           WarmW    = $clog2(LAT + 1);
    localparam logic [WarmW-1:0]      WarmLoad = WarmW'(LAT);
    localparam logic [CNT_W-1:0]      CntMax   = '1;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StSync  = 2'b01,
        StCheck = 2'b10,
        StFail  = 2'b11
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WarmW-1:0] r_warm;
    logic [WarmW-1:0] w_warm_nxt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] w_err_nxt;
    logic [CNT_W-1:0] r_chk_cnt;
    logic [CNT_W-1:0] w_chk_nxt;
    logic             r_mismatch;
    logic             w_mismatch_nxt;
    logic             r_model;
    logic             w_model_nxt;
    logic             r_exp_frz;
    logic             w_exp_line;
    logic             w_diff;

    // Reference JK model; tracks the DUT every edge independent of checker state.
    always_comb begin
        w_model_nxt = r_model;
        if (!dut_rstn) begin
            w_model_nxt = 1'b0;
        end else begin
            unique case ({j, k})
                2'b00:   w_model_nxt = r_model;
                2'b01:   w_model_nxt = 1'b0;
                2'b10:   w_model_nxt = 1'b1;
                2'b11:   w_model_nxt = ~r_model;
                default: w_model_nxt = r_model;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_model <= 1'b0;
        end else begin
            r_model <= w_model_nxt;
        end
    end

    generate
        if (LAT > 1) begin : g_delay
            logic [LAT-2:0] r_dly;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_dly <= '0;
                end else begin
                    r_dly[0] <= r_model;
                    for (int i = 1; i < int'(LAT) - 1; i++) begin
                        r_dly[i] <= r_dly[i-1];
                    end
                end
            end

            assign w_exp_line = r_dly[LAT-2];
        end else begin : g_no_delay
            assign w_exp_line = r_model;
        end
    endgenerate

    // Snapshot of the aligned expectation so exp_q stays put while parked in FAIL.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_exp_frz <= 1'b0;
        end else if (r_state != StFail) begin
            r_exp_frz <= w_exp_line;
        end
    end

    assign w_diff = dut_q ^ w_exp_line;

    always_comb begin
        w_state_nxt    = r_state;
        w_warm_nxt     = r_warm;
        w_err_nxt      = r_err_cnt;
        w_chk_nxt      = r_chk_cnt;
        w_mismatch_nxt = 1'b0;

        if (!en) begin
            w_state_nxt = StIdle;
        end else begin
            if (clr) begin
                w_err_nxt = '0;
                w_chk_nxt = '0;
            end
            unique case (r_state)
                StIdle: begin
                    w_state_nxt = StSync;
                    w_warm_nxt  = WarmLoad;
                end
                StSync: begin
                    w_warm_nxt = (r_warm != '0) ? r_warm - 1'b1 : '0;
                    if (r_warm <= WarmW'(1)) begin
                        w_state_nxt = StCheck;
                    end
                end
                StCheck: begin
                    // A same-edge clear suppresses the compare entirely.
                    if (!clr) begin
                        w_chk_nxt = (r_chk_cnt == CntMax) ? r_chk_cnt : r_chk_cnt + 1'b1;
                        if (w_diff) begin
                            w_err_nxt      = (r_err_cnt == CntMax) ? r_err_cnt : r_err_cnt + 1'b1;
                            w_mismatch_nxt = 1'b1;
                            if (STOP_ON_FAIL) begin
                                w_state_nxt = StFail;
                            end
                        end
                    end
                end
                StFail: begin
                    if (clr) begin
                        w_state_nxt = StIdle;
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= StIdle;
            r_warm     <= '0;
            r_err_cnt  <= '0;
            r_chk_cnt  <= '0;
            r_mismatch <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_warm     <= w_warm_nxt;
            r_err_cnt  <= w_err_nxt;
            r_chk_cnt  <= w_chk_nxt;
            r_mismatch <= w_mismatch_nxt;
        end
    end

    assign exp_q    = (r_state == StFail) ? r_exp_frz : w_exp_line;
    assign mismatch = r_mismatch;
    assign err_cnt  = r_err_cnt;
    assign chk_cnt  = r_chk_cnt;
    assign state    = r_state;

endmodule

// File: tb/tb_jk_ff_checker.sv
// Bench for jk_ff_checker: four checker instances with different parameters watch stand-in
// JK DUTs; an abstract model is compared every cycle, plus hand-computed literal checks.
module tb_jk_ff_checker;

    logic clk      = 1'b0;
    logic rstn     = 1'b1;
    logic en       = 1'b0;
    logic clr      = 1'b0;
    logic j        = 1'b0;
    logic k        = 1'b0;
    logic dut_rstn = 1'b0;
    logic inj      = 1'b0;
    logic stuck    = 1'b0;
    logic done     = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Stand-in DUTs: a plain JK flop plus a two-stage tail for the 3-edge-latency variant.
    logic dq1 = 1'b0;
    logic d2  = 1'b0;
    logic d3  = 1'b0;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dq1 <= 1'b0;
            d2  <= 1'b0;
            d3  <= 1'b0;
        end else begin
            d2 <= dq1;
            d3 <= d2;
            if (!dut_rstn) dq1 <= 1'b0;
            else if (j && k) dq1 <= ~dq1;
            else if (j) dq1 <= 1'b1;
            else if (k) dq1 <= 1'b0;
        end
    end

    logic q_inj;
    logic q_stuck;
    assign q_inj   = dq1 ^ inj;
    assign q_stuck = stuck ? 1'b0 : dq1;

    logic       exp_o [4];
    logic       mis_o [4];
    logic [1:0] st_o  [4];
    logic [7:0] err0, chk0, err1, chk1, err3, chk3;
    logic [1:0] err2, chk2;
    logic [7:0] act_err [4];
    logic [7:0] act_chk [4];

    assign act_err[0] = err0;
    assign act_err[1] = err1;
    assign act_err[2] = {6'b0, err2};
    assign act_err[3] = err3;
    assign act_chk[0] = chk0;
    assign act_chk[1] = chk1;
    assign act_chk[2] = {6'b0, chk2};
    assign act_chk[3] = chk3;

    jk_ff_checker #(.CNT_W(8), .LAT(1), .STOP_ON_FAIL(1'b0)) u0 (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .j(j), .k(k), .dut_rstn(dut_rstn),
        .dut_q(q_inj), .exp_q(exp_o[0]), .mismatch(mis_o[0]), .err_cnt(err0),
        .chk_cnt(chk0), .state(st_o[0]));

    jk_ff_checker #(.CNT_W(8), .LAT(1), .STOP_ON_FAIL(1'b1)) u1 (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .j(j), .k(k), .dut_rstn(dut_rstn),
        .dut_q(q_inj), .exp_q(exp_o[1]), .mismatch(mis_o[1]), .err_cnt(err1),
        .chk_cnt(chk1), .state(st_o[1]));

    jk_ff_checker #(.CNT_W(2), .LAT(1), .STOP_ON_FAIL(1'b0)) u2 (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .j(j), .k(k), .dut_rstn(dut_rstn),
        .dut_q(q_stuck), .exp_q(exp_o[2]), .mismatch(mis_o[2]), .err_cnt(err2),
        .chk_cnt(chk2), .state(st_o[2]));

    jk_ff_checker #(.CNT_W(8), .LAT(3), .STOP_ON_FAIL(1'b0)) u3 (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .j(j), .k(k), .dut_rstn(dut_rstn),
        .dut_q(d3), .exp_q(exp_o[3]), .mismatch(mis_o[3]), .err_cnt(err3),
        .chk_cnt(chk3), .state(st_o[3]));

    // ---------------- abstract model ----------------
    int lat_p [4] = '{1, 1, 1, 3};
    int cw_p  [4] = '{8, 8, 2, 8};
    int sof_p [4] = '{0, 1, 0, 0};

    int hist   [4];  // JK value after the most recent edges, newest first
    int since  [4];  // consecutive edges with en high since last idle
    int failed [4];
    int frz    [4];
    int merr   [4];
    int mchk   [4];
    int mmis   [4];
    int pe     [4];
    int pq     [4];
    int nv;
    int mx;

    function automatic int sat(int v, int lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic int mexp(int i);
        return (failed[i] != 0) ? frz[i] : hist[lat_p[i] - 1];
    endfunction

    function automatic int mstate(int i);
        if (since[i] == 0) return 0;
        if (failed[i] != 0) return 3;
        if (since[i] <= lat_p[i]) return 1;
        return 2;
    endfunction

    function automatic int dutq(int i);
        if (i < 2) return int'(q_inj);
        if (i == 2) return int'(q_stuck);
        return int'(d3);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            hist[i]   = 0;
            since[i]  = 0;
            failed[i] = 0;
            frz[i]    = 0;
            merr[i]   = 0;
            mchk[i]   = 0;
            mmis[i]   = 0;
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                model_clear();
            end else begin
                for (int i = 0; i < 4; i++) begin
                    pe[i] = mexp(i);
                    pq[i] = dutq(i);
                end
                for (int i = 0; i < 4; i++) begin
                    mx = (1 << cw_p[i]) - 1;
                    if (!en) begin
                        since[i]  = 0;
                        failed[i] = 0;
                        mmis[i]   = 0;
                    end else if (clr) begin
                        merr[i] = 0;
                        mchk[i] = 0;
                        mmis[i] = 0;
                        if (failed[i] != 0) begin
                            failed[i] = 0;
                            since[i]  = 0;
                        end else begin
                            since[i] = sat(since[i] + 1, lat_p[i] + 1);
                        end
                    end else begin
                        mmis[i] = 0;
                        if (mstate(i) == 2) begin
                            mchk[i] = sat(mchk[i] + 1, mx);
                            if (pq[i] != pe[i]) begin
                                merr[i] = sat(merr[i] + 1, mx);
                                mmis[i] = 1;
                                if (sof_p[i] != 0) begin
                                    failed[i] = 1;
                                    frz[i]    = pe[i];
                                end
                            end
                        end
                        if (failed[i] == 0) since[i] = sat(since[i] + 1, lat_p[i] + 1);
                    end
                end
                if (!dut_rstn) nv = 0;
                else if (j && k) nv = 1 - hist[0];
                else if (j) nv = 1;
                else if (k) nv = 0;
                else nv = hist[0];
                for (int s = 3; s > 0; s--) hist[s] = hist[s-1];
                hist[0] = nv;
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!done) begin
                for (int i = 0; i < 4; i++) begin
                    check($sformatf("u%0d.exp_q", i), 16'(exp_o[i]), 16'(mexp(i)));
                    check($sformatf("u%0d.mismatch", i), 16'(mis_o[i]), 16'(mmis[i]));
                    check($sformatf("u%0d.state", i), 16'(st_o[i]), 16'(mstate(i)));
                    check($sformatf("u%0d.err_cnt", i), 16'(act_err[i]), 16'(merr[i]));
                    check($sformatf("u%0d.chk_cnt", i), 16'(act_chk[i]), 16'(mchk[i]));
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    logic [1:0] seq_jk  [6] = '{2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b00};
    logic       seq_exp [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0] sat_err [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    logic [1:0] mix_jk  [8] = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b11, 2'b10, 2'b11, 2'b00};

    initial begin
        #1 rstn = 1'b0;
        step();
        check("reset.state", 16'(st_o[0]), 16'd0);
        check("reset.err", 16'(act_err[0]), 16'd0);
        check("reset.chk", 16'(act_chk[0]), 16'd0);
        check("reset.exp", 16'(exp_o[0]), 16'd0);
        step();
        rstn = 1'b1;
        dut_rstn = 1'b1;
        step();
        en = 1'b1;
        step();
        check("sync.u0", 16'(st_o[0]), 16'd1);
        check("sync.u3", 16'(st_o[3]), 16'd1);
        step();
        check("check.u0", 16'(st_o[0]), 16'd2);
        repeat (3) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            {j, k} = seq_jk[i];
            step();
            check($sformatf("seq.exp%0d", i), 16'(exp_o[0]), 16'(seq_exp[i]));
        end
        check("seq.chk", 16'(act_chk[0]), 16'd6);
        check("seq.err", 16'(act_err[0]), 16'd0);
        check("seq.state", 16'(st_o[0]), 16'd2);

        {j, k} = 2'b00;
        inj = 1'b1;
        step();
        check("fault.mis", 16'(mis_o[0]), 16'd1);
        check("fault.err", 16'(act_err[0]), 16'd1);
        check("fault.state0", 16'(st_o[0]), 16'd2);
        check("fault.state1", 16'(st_o[1]), 16'd3);
        inj = 1'b0;
        step();
        check("fault.mis_off", 16'(mis_o[0]), 16'd0);
        repeat (2) step();
        check("fail.chk_frozen", 16'(act_chk[1]), 16'd7);
        check("fail.state", 16'(st_o[1]), 16'd3);
        check("nofail.chk", 16'(act_chk[0]), 16'd10);
        clr = 1'b1;
        step();
        check("clr.state1", 16'(st_o[1]), 16'd0);
        check("clr.chk1", 16'(act_chk[1]), 16'd0);
        check("clr.err1", 16'(act_err[1]), 16'd0);
        clr = 1'b0;
        repeat (2) step();
        inj = 1'b1;
        clr = 1'b1;
        step();
        check("clrwin.state", 16'(st_o[1]), 16'd2);
        check("clrwin.err", 16'(act_err[1]), 16'd0);
        check("clrwin.chk", 16'(act_chk[1]), 16'd0);
        check("clrwin.mis", 16'(mis_o[1]), 16'd0);
        inj = 1'b0;

        stuck = 1'b1;
        {j, k} = 2'b10;
        step();
        clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("satur.err%0d", i), 16'(err2), 16'(sat_err[i]));
        end
        check("satur.chk", 16'(chk2), 16'd3);
        stuck = 1'b0;
        step();

        dut_rstn = 1'b0;
        step();
        check("dutrst.exp", 16'(exp_o[0]), 16'd0);
        check("dutrst.mis", 16'(mis_o[0]), 16'd0);
        dut_rstn = 1'b1;
        step();
        check("dutrst.err", 16'(act_err[0]), 16'd0);

        {j, k} = 2'b00;
        step();
        #2 rstn = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("arst.state%0d", i), 16'(st_o[i]), 16'd0);
            check($sformatf("arst.chk%0d", i), 16'(act_chk[i]), 16'd0);
            check($sformatf("arst.err%0d", i), 16'(act_err[i]), 16'd0);
            check($sformatf("arst.exp%0d", i), 16'(exp_o[i]), 16'd0);
        end
        step();
        rstn = 1'b1;
        {j, k} = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("lat3.sync%0d", i), 16'(st_o[3]), 16'd1);
        end
        step();
        check("lat3.check", 16'(st_o[3]), 16'd2);
        check("lat3.chk0", 16'(chk3), 16'd0);
        step();
        check("lat3.chk1", 16'(chk3), 16'd1);
        for (int i = 0; i < 8; i++) begin
            {j, k} = mix_jk[i];
            step();
        end
        check("lat3.err", 16'(err3), 16'd0);
        check("mix.err0", 16'(act_err[0]), 16'd0);
        en = 1'b0;
        step();
        check("en_off.state0", 16'(st_o[0]), 16'd0);
        check("en_off.state3", 16'(st_o[3]), 16'd0);
        step();
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
